clock_divider: RTL and testbench
================================

// Module: clock_divider
// PURPOSE
//   Enable-gated clock divider. Counts cycles of the system clock and toggles a
//   slow square-wave output every THRESHOLD enabled cycles. Feeds slow timing
//   logic such as the reaction-timer display/scan blocks. The output is a
//   registered signal in the clk domain. Consumers sample it as data or as an
//   edge source; it does not drive global clock nets.
// PARAMETERS
//   THRESHOLD  50000  enabled clk cycles per output half-period; legal range >= 1
//   CW         derived localparam = max(1, $clog2(THRESHOLD)); counter width
// PORTS
//   clk         in   1   system clock; all state changes on its rising edge
//   reset       in   1   asynchronous, active-high reset
//   enable      in   1   count enable; when low, counter and output hold
//   dividedClk  out  1   divided square wave, period 2*THRESHOLD enabled cycles
//   tick        out  1   only with CLOCK_DIVIDER_TICK_EN; see CONFIGURATION
// BEHAVIOUR
//   - One clock, clk. Reset is asynchronous and active-high.
//   - Reset asserted: count=0 and dividedClk=0 immediately, without waiting for
//     a clk edge. They stay at 0 while reset is held.
//   - Each rising clk edge with reset=0 and enable=1:
//       - count == THRESHOLD-1: count <= 0 and dividedClk <= ~dividedClk.
//       - otherwise: count <= count+1 and dividedClk holds.
//   - enable=0: count and dividedClk both freeze. No phase loss when enable
//     returns.
//   - First toggle of dividedClk (0->1) happens at the THRESHOLD-th enabled
//     edge after reset. Later toggles follow every THRESHOLD enabled edges.
//     Duty cycle is 50% while enable is held high.
//   - THRESHOLD=1: dividedClk toggles on every enabled edge, giving clk/2.
//   - Counter wrap is explicit at THRESHOLD-1. There is no reliance on natural
//     overflow. The compare uses a CW-bit constant.
//   - Reset mid-period discards the partial count. Counting restarts from 0 on
//     the first enabled edge after reset deasserts.
//   - Reset has priority over enable.
//   - THRESHOLD < 1 is illegal. The RTL flags it with an elaboration-time
//     $error.
// CONFIGURATION
//   - CLOCK_DIVIDER_TICK_EN defined:
//       - The module adds output port tick.
//       - tick is registered. It is 1 for exactly the one clk cycle that
//         follows each wrap edge, i.e. it is high in the same cycle that
//         dividedClk shows its new value. It is 0 at all other times.
//       - Reset value of tick is 0.
//       - tick does not assert while enable=0.
//   - CLOCK_DIVIDER_TICK_EN undefined: the tick port and its logic are absent.
//     Behaviour of dividedClk is identical in both builds.
// STRUCTURE
//   - Package clock_divider_pkg holds:
//       - DEFAULT_THRESHOLD = 50000
//       - function div_width(int t), returning max(1, $clog2(t))
//   - One sub-module, clock_divider_counter: the CW-bit counter with
//     enable/wrap. It outputs wrap (the combinational count==THRESHOLD-1 &&
//     enable).
//   - The top level keeps the dividedClk toggle flop and the optional tick flop.
// TESTING
//   All scenarios use THRESHOLD=4 unless stated otherwise, and a 10 ns clk.
//   1. Reset held, enable=0 for 3 cycles: dividedClk=0, count=0. Release
//      reset, keep enable=0 for 5 cycles: dividedClk stays 0.
//   2. enable=1 continuously after reset: dividedClk rises after the 4th
//      enabled edge, falls after the 8th. Period is 80 ns and duty is 50%.
//   3. Enable gating:
//        - enable high for 2 edges, low for 5, high again.
//        - Required: toggle on the 2nd edge after re-enable (4 enabled edges in
//          total).
//   4. Assert reset asynchronously mid-period, between clk edges, while
//      dividedClk=1: dividedClk goes 0 at once. After release, the first rise
//      comes 4 enabled edges later.
//   5. Rebuild with THRESHOLD=1: dividedClk toggles every enabled edge (clk/2).
//      Rebuild with THRESHOLD=50000: first rise at 500 us after enable.
//   6. With CLOCK_DIVIDER_TICK_EN: tick is a 1-cycle pulse coincident with each
//      new dividedClk value, with 4 pulses per 160 ns. Without the macro the
//      module elaborates with 4 ports only.

Source files
------------

// File: rtl/clock_divider_pkg.sv
// clock_divider_pkg: shared constants and width helper for the clock divider
package clock_divider_pkg;
  localparam int DEFAULT_THRESHOLD = 50000;
  function automatic int div_width(int t);
    return ($clog2(t) < 1) ? 1 : $clog2(t);
  endfunction
endpackage

// File: rtl/clock_divider_counter.sv
// clock_divider_counter: enable-gated counter that wraps explicitly at THRESHOLD-1
module clock_divider_counter
  import clock_divider_pkg::*;
#(
  parameter int THRESHOLD = DEFAULT_THRESHOLD,
  parameter int CW        = div_width(THRESHOLD)
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  output logic o_wrap
);
  localparam logic [CW-1:0] LAST = CW'(THRESHOLD - 1);
  logic [CW-1:0] r_count;
  assign o_wrap = i_en && (r_count == LAST);
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) r_count <= '0;
    else if (i_en) r_count <= o_wrap ? '0 : r_count + 1'b1;
endmodule

// File: rtl/clock_divider.sv
// clock_divider: toggles dividedClk every THRESHOLD enabled clk cycles.
// Define CLOCK_DIVIDER_TICK_EN to add a one-cycle tick output per toggle.
module clock_divider
  import clock_divider_pkg::*;
#(
  parameter int THRESHOLD = DEFAULT_THRESHOLD
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic dividedClk
`ifdef CLOCK_DIVIDER_TICK_EN
  ,output logic tick
`endif
);
  localparam int CW = div_width(THRESHOLD);
  if (THRESHOLD < 1) begin : g_bad_threshold
    $error("clock_divider: THRESHOLD must be >= 1");
  end
  logic w_wrap;
  logic r_div;
  clock_divider_counter #(.THRESHOLD(THRESHOLD), .CW(CW)) u_counter (
    .i_clk (clk),
    .i_rst (reset),
    .i_en  (enable),
    .o_wrap(w_wrap)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) r_div <= 1'b0;
    else if (w_wrap) r_div <= ~r_div;
  assign dividedClk = r_div;
`ifdef CLOCK_DIVIDER_TICK_EN
  // Registered from the same wrap as r_div, so it lines up with the new level
  logic r_tick;
  always_ff @(posedge clk or posedge reset)
    if (reset) r_tick <= 1'b0;
    else r_tick <= w_wrap;
  assign tick = r_tick;
`endif
endmodule

// File: tb/tb_clock_divider.sv
// tb_clock_divider: randomized and directed checks of clock_divider (THRESHOLD 4 and 1)
module tb_clock_divider;
  logic clk, reset, enable;
  logic div4, div1;
  int   n, vec, errs;
  logic last_en;
  time  t_rise, t_fall, t_rise2;
`ifdef CLOCK_DIVIDER_TICK_EN
  logic tick4, tick1;
`endif

  clock_divider #(.THRESHOLD(4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .dividedClk(div4)
`ifdef CLOCK_DIVIDER_TICK_EN
    , .tick(tick4)
`endif
  );
  clock_divider #(.THRESHOLD(1)) dut1 (
    .clk(clk), .reset(reset), .enable(enable), .dividedClk(div1)
`ifdef CLOCK_DIVIDER_TICK_EN
    , .tick(tick1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string tag, input logic obs, input logic exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%b expected=%b (n=%0d t=%0t)", tag, obs, exp, n, $time);
    end
  endtask

  // Model: n = enabled edges since reset; output level is the parity of n/THRESHOLD
  task automatic check_all(input string tag);
    cmp({tag, "_div4"}, div4, ((n / 4) % 2) == 1);
    cmp({tag, "_div1"}, div1, (n % 2) == 1);
`ifdef CLOCK_DIVIDER_TICK_EN
    cmp({tag, "_tick4"}, tick4, last_en && n > 0 && (n % 4) == 0);
    cmp({tag, "_tick1"}, tick1, last_en);
`endif
  endtask

  task automatic step(input logic en, input string tag);
    @(negedge clk);
    enable = en;
    @(posedge clk);
    if (reset) n = 0;
    else if (en) n++;
    last_en = !reset && en;
    #1;
    check_all(tag);
  endtask

  task automatic async_reset(input string tag);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    n = 0;
    last_en = 1'b0;
    check_all({tag, "_imm"});
    @(posedge clk);
    #1;
    check_all({tag, "_held"});
    @(negedge clk);
    reset = 1'b0;
    enable = 1'b0;
  endtask

  initial begin
    vec = 0;
    errs = 0;
    n = 0;
    last_en = 1'b0;
    enable = 1'b0;
    reset = 1'b1;
    #1;
    check_all("reset_t0");
    for (int i = 0; i < 3; i++) step(1'b0, "reset_held");
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) step(1'b0, "idle_en0");
    for (int i = 1; i <= 12; i++) begin
      step(1'b1, "run");
      if (i == 4) t_rise = $time;
      if (i == 8) t_fall = $time;
      if (i == 12) t_rise2 = $time;
    end
    vec++;
    assert (t_fall - t_rise == 40 && t_rise2 - t_rise == 80) else begin
      errs++;
      $error("FAIL period observed=%0t/%0t expected=40/80", t_fall - t_rise, t_rise2 - t_rise);
    end
    async_reset("rst_gate");
    step(1'b1, "gate_a");
    step(1'b1, "gate_b");
    for (int i = 0; i < 5; i++) step(1'b0, "gate_off");
    step(1'b1, "gate_c");
    step(1'b1, "gate_d");
    for (int i = 0; i < 6; i++) step(1'b1, "gate_after");
    while (((n / 4) % 2) != 1) step(1'b1, "to_high");
    step(1'b1, "mid_high");
    async_reset("rst_mid");
    for (int i = 0; i < 5; i++) step(1'b1, "after_rst");
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) async_reset("rand_rst");
      else step($urandom_range(0, 3) != 0, "rand");
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
